io_bus_arb: RTL

- Shares the single CPU-side IO bus between two requesters: m0 (CPU load/store port) and m1 (console/DMA engine that fills VGA text memory and drains keyboard data).
- The shared bus feeds the IO address decoder, which selects dmem, VGA, keyboard or VGA offset/colour from addr[31:20].
- Decisions are made cycle by cycle: round-robin with burst holding and a starvation limit.
- Read data is returned one cycle after the beat to the master that issued it.

---
 rtl/io_pkg.sv | 18 +
 rtl/rr_pick2.sv | 23 ++
 rtl/io_bus_arb.sv | 116 +++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared constants for the CPU-side IO bus: region codes,
// default widths and master indices.
package io_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  // addr[31:20] region codes seen by the IO decoder
  localparam logic [11:0] IO_DMEM       = 12'h001;
  localparam logic [11:0] IO_VGA        = 12'h002;
  localparam logic [11:0] IO_KEY        = 12'h003;
  localparam logic [11:0] IO_VGA_OFFSET = 12'h004;
  localparam logic [11:0] IO_VGA_COLOR  = 12'h005;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way combinational pick: the holder keeps the bus while
// hold is set, otherwise the non-owner wins a contended cycle.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       owner,
  input  logic       hold,
  output logic [1:0] gnt
);

  logic win;

  always_comb begin
    gnt = 2'b00;
    win = hold ? owner : ~owner;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = win ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/io_bus_arb.sv
// Arbiter sharing the CPU IO bus between the CPU port (m0)
// and the console/DMA engine (m1), with one-cycle read return.
module io_bus_arb
  import io_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_en,
  output logic          bus_rd,
  input  logic [DW-1:0] bus_rdata
);

  localparam logic [3:0] LIMIT = 4'(MAX_BURST);

  logic       owner;
  logic [3:0] burst_cnt;
  logic       rd_pend;
  logic       rd_tag;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       hold;
  logic       any;
  logic       idx;
  logic       sel_we;

  // nonzero count means the owner also won the previous cycle
  assign hold = (burst_cnt != 4'd0) && (burst_cnt < LIMIT);
  assign req  = {m1_req, m0_req} & {2{rst_n}};

  rr_pick2 u_pick (
    .req   (req),
    .owner (owner),
    .hold  (hold),
    .gnt   (gnt)
  );

  assign any = |gnt;
  assign idx = gnt[M_DMA];

  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    sel_we    = 1'b0;
    unique case (1'b1)
      gnt[M_CPU]: begin
        bus_addr  = m0_addr;
        bus_wdata = m0_wdata;
        sel_we    = m0_we;
      end
      gnt[M_DMA]: begin
        bus_addr  = m1_addr;
        bus_wdata = m1_wdata;
        sel_we    = m1_we;
      end
      default: ;
    endcase
  end

  // bus_rd only on a granted read: keyboard pops are destructive
  assign bus_en = any & sel_we;
  assign bus_rd = any & ~sel_we;

  assign m0_gnt = gnt[M_CPU];
  assign m1_gnt = gnt[M_DMA];

  assign m0_rvalid = rst_n & rd_pend & (rd_tag == M_CPU);
  assign m1_rvalid = rst_n & rd_pend & (rd_tag == M_DMA);
  assign m0_rdata  = m0_rvalid ? bus_rdata : '0;
  assign m1_rdata  = m1_rvalid ? bus_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner     <= 1'b1;
      burst_cnt <= 4'd0;
      rd_pend   <= 1'b0;
      rd_tag    <= 1'b0;
    end else begin
      rd_pend <= bus_rd;
      if (bus_rd) begin
        rd_tag <= idx;
      end
      if (!any) begin
        burst_cnt <= 4'd0;
      end else if (idx == owner && burst_cnt != 4'd0) begin
        if (burst_cnt != 4'hf) begin
          burst_cnt <= burst_cnt + 4'd1;
        end
      end else begin
        owner     <= idx;
        burst_cnt <= 4'd1;
      end
    end
  end

endmodule
